// File: rtl/core_pkg.sv
// core_pkg: opcodes, FSM states and instruction
// field positions shared by multicycle_core and core_alu.
package core_pkg;

  typedef enum logic [2:0] {
    OP_XOR  = 3'd0,
    OP_BEQ  = 3'd1,
    OP_ADDI = 3'd2,
    OP_ANDI = 3'd3,
    OP_LS   = 3'd4,
    OP_LD   = 3'd5,
    OP_ST   = 3'd6,
    OP_J    = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 0;
  localparam int BEQ_SEL = 5;
  localparam int BEQ_VAL = 4;
  localparam int OFF_MSB = 3;

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational ALU for the 9-bit ISA.
// Ports: op (opcode), a, b, imm -> result, eq (a == b).
module core_alu
  import core_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    imm,
  output logic [DW-1:0] result,
  output logic          eq
);

  always_comb begin
    result = a;
    unique case (opcode_e'(op))
      OP_XOR:  result = a ^ b;
      OP_ADDI: result = a + DW'($signed(imm));
      OP_ANDI: result = a & DW'(imm);
      OP_LS:   result = a << imm;
      default: result = a;
    endcase
  end

  assign eq = (a == b);

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 9-bit-ISA CPU with sync imem,
// req/ready dmem, halt on jump-to-self, retired counter.
// Ports: clk, reset (async low), start; imem_addr/rdata;
// dmem_req/we/addr/wdata/rdata/ready; dbg_raddr/rdata;
// busy, done, retired.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DW       = 8,
  parameter int PCW      = 10,
  parameter int CW       = 16,
  parameter int RESET_PC = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [PCW-1:0] imem_addr,
  input  logic [8:0]     imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic           dmem_ready,
  input  logic [2:0]     dbg_raddr,
  output logic [DW-1:0]  dbg_rdata,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  retired
);

  localparam logic [PCW-1:0] PC0 = PCW'(RESET_PC);

  state_e         state;
  state_e         state_n;
  logic [PCW-1:0] pc;
  logic [PCW-1:0] pc_n;
  logic [DW-1:0]  rf [8];
  logic [2:0]     mem_rd;

  logic [2:0]     op;
  logic [2:0]     rd;
  logic [2:0]     rs;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] br_tgt;
  logic [PCW-1:0] j_tgt;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_y;
  logic           alu_eq;

  logic           rf_we;
  logic [2:0]     rf_wa;
  logic [DW-1:0]  rf_wd;
  logic           retire;
  logic           restart;
  logic           mem_latch;

  assign op = imem_rdata[OP_MSB:OP_LSB];
  assign rd = imem_rdata[RD_MSB:RD_LSB];
  assign rs = imem_rdata[RS_MSB:RS_LSB];

  assign pc_inc = pc + PCW'(1);
  assign br_tgt = pc
    + PCW'($signed(imem_rdata[OFF_MSB:0]));
  assign j_tgt  = PCW'(imem_rdata[RD_MSB:0]);

  // BEQ tests R0/R1 against a 1-bit constant
  assign alu_a = (op == OP_BEQ)
    ? rf[{2'b00, imem_rdata[BEQ_SEL]}]
    : rf[rd];
  assign alu_b = (op == OP_BEQ)
    ? DW'(imem_rdata[BEQ_VAL])
    : rf[rs];

  core_alu #(
    .DW(DW)
  ) u_alu (
    .op    (op),
    .a     (alu_a),
    .b     (alu_b),
    .imm   (rs),
    .result(alu_y),
    .eq    (alu_eq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    rf_we     = 1'b0;
    rf_wa     = rd;
    rf_wd     = alu_y;
    retire    = 1'b0;
    restart   = 1'b0;
    mem_latch = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = PC0;
          restart = 1'b1;
        end
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        unique case (opcode_e'(op))
          OP_XOR, OP_ADDI, OP_ANDI, OP_LS: begin
            rf_we   = 1'b1;
            pc_n    = pc_inc;
            retire  = 1'b1;
            state_n = S_FETCH;
          end
          OP_BEQ: begin
            pc_n    = alu_eq ? br_tgt : pc_inc;
            retire  = 1'b1;
            state_n = S_FETCH;
          end
          OP_J: begin
            pc_n    = j_tgt;
            retire  = 1'b1;
            state_n = (j_tgt == pc)
              ? S_HALT : S_FETCH;
          end
          OP_LD, OP_ST: begin
            mem_latch = 1'b1;
            state_n   = S_MEM;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          rf_we   = !dmem_we;
          rf_wa   = mem_rd;
          rf_wd   = dmem_rdata;
          pc_n    = pc_inc;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= PC0;
      retired    <= '0;
      mem_rd     <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      pc <= pc_n;
      if (rf_we) rf[rf_wa] <= rf_wd;
      if (restart)
        retired <= '0;
      else if (retire && retired != '1)
        retired <= retired + CW'(1);
      // memory operands frozen for the whole MEM wait
      if (mem_latch) begin
        mem_rd     <= rd;
        dmem_we    <= (op == OP_ST);
        dmem_addr  <= rf[rs];
        dmem_wdata <= rf[rd];
      end
    end
  end

  assign imem_addr = pc;
  assign dmem_req  = (state == S_MEM);
  assign busy      = (state == S_FETCH)
                  || (state == S_EXEC)
                  || (state == S_MEM);
  assign done      = (state == S_HALT);
  assign dbg_rdata = rf[dbg_raddr];

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench with an ISA-level
// reference model, ROM and variable-latency memory model.
`timescale 1ns/1ps
module tb_multicycle_core;
  import core_pkg::*;

  localparam int DW  = 8;
  localparam int PCW = 10;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [PCW-1:0] imem_addr;
  logic [8:0]     imem_rdata = '0;
  logic           dmem_req;
  logic           dmem_we;
  logic [DW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic [DW-1:0]  dmem_rdata = '0;
  logic           dmem_ready = 1'b0;
  logic [2:0]     dbg_raddr = '0;
  logic [DW-1:0]  dbg_rdata;
  logic           busy;
  logic           done;
  logic [CW-1:0]  retired;

  multicycle_core #(
    .DW(DW), .PCW(PCW), .CW(CW), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata),
    .busy(busy), .done(done),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, got, want);
    end
  endtask

  typedef struct {
    bit halt;
    bit we;
    int addr;
    int data;
    int ret;
    int pc;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] rom[1024];
  int         mregs[8];
  int         mmem[256];
  int         tbmem[256];
  int         force_stall = -1;
  bit         noise = 1'b0;
  int         last_req_len = 0;

  function automatic logic [8:0] enc(
    input logic [2:0] o, input int a, input int b);
    return {o, 3'(a), 3'(b)};
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 1024; i++)
      rom[i] = {OP_J, 6'(i % 64)};
  endtask

  // ISA-level model: runs the program to its halt,
  // queueing memory accesses and the halt event.
  task automatic model_run();
    int pc = 0;
    int n = 0;
    int steps = 0;
    int op, rd, rs, v, a;
    logic [8:0] ins;
    exp_t e;
    while (1) begin
      ins = rom[pc];
      op = int'(ins[8:6]);
      rd = int'(ins[5:3]);
      rs = int'(ins[2:0]);
      n++;
      e = '{0, 0, 0, 0, 0, 0};
      case (op)
        0: begin
          mregs[rd] = mregs[rd] ^ mregs[rs];
          pc++;
        end
        1: begin
          v = int'(ins[3:0]);
          if (v >= 8) v -= 16;
          if (mregs[int'(ins[5])] == int'(ins[4]))
            pc = (pc + v + 1024) % 1024;
          else
            pc = (pc + 1) % 1024;
        end
        2: begin
          v = (rs >= 4) ? rs - 8 : rs;
          mregs[rd] = (mregs[rd] + v + 256) % 256;
          pc++;
        end
        3: begin
          mregs[rd] = mregs[rd] & rs;
          pc++;
        end
        4: begin
          mregs[rd] = (mregs[rd] * (1 << rs)) % 256;
          pc++;
        end
        5: begin
          a = mregs[rs];
          e.addr = a;
          exp_q.push_back(e);
          mregs[rd] = mmem[a];
          pc++;
        end
        6: begin
          a = mregs[rs];
          e.we = 1;
          e.addr = a;
          e.data = mregs[rd];
          exp_q.push_back(e);
          mmem[a] = mregs[rd];
          pc++;
        end
        default: begin
          if (int'(ins[5:0]) == pc) begin
            e.halt = 1;
            e.ret = (n > SAT) ? SAT : n;
            e.pc = pc;
            exp_q.push_back(e);
            break;
          end
          pc = int'(ins[5:0]);
        end
      endcase
      steps++;
      if (steps > 5000) begin
        errors++;
        $display("FAIL model_runaway pc=%0d", pc);
        break;
      end
    end
  endtask

  // instruction ROM: data one cycle after address
  always @(posedge clk) begin
    logic [8:0] d;
    d = rom[imem_addr];
    #1 imem_rdata = d;
  end

  // data memory responder with per-request stall count
  bit in_req = 1'b0;
  int req_cnt = 0;
  int tgt = 0;
  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        req_cnt = 0;
        tgt = (force_stall >= 0) ? force_stall
                                 : $urandom_range(0, 3);
      end else begin
        req_cnt++;
      end
      dmem_ready = (req_cnt >= tgt);
      dmem_rdata = 8'(tbmem[dmem_addr]);
    end else begin
      in_req = 1'b0;
      dmem_ready = noise ? 1'($urandom_range(0, 1))
                         : 1'b0;
      dmem_rdata = 8'($urandom);
    end
  end

  // monitor: pops the scoreboard on each completed
  // memory access and on each halt
  int   req_len = 0;
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;
  logic [16:0] prev_bus = '0;
  always @(negedge clk) begin
    exp_t e;
    if (dmem_req) begin
      if (prev_req)
        check("dmem_stable",
              {dmem_we, dmem_addr, dmem_wdata}, prev_bus);
      req_len++;
      if (dmem_ready) begin
        last_req_len = req_len;
        req_len = 0;
        if (exp_q.size() == 0) begin
          check("dmem_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 0, e.halt);
          check("dmem_we", dmem_we, e.we);
          check("dmem_addr", dmem_addr, e.addr);
          if (e.we)
            check("dmem_wdata", dmem_wdata, e.data);
        end
        if (dmem_we) tbmem[dmem_addr] = dmem_wdata;
      end
    end else begin
      req_len = 0;
    end
    if (done && !prev_done) begin
      if (exp_q.size() == 0) begin
        check("halt_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 1, e.halt);
        check("halt_retired", retired, e.ret);
        check("halt_pc", imem_addr, e.pc);
      end
    end
    prev_req = dmem_req;
    prev_done = done;
    prev_bus = {dmem_we, dmem_addr, dmem_wdata};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic launch();
    model_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!done && c < maxc) begin
      tick();
      c++;
    end
    if (!done) begin
      check("halt_timeout", done, 1);
      exp_q.delete();
    end
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #1;
      check($sformatf("reg_r%0d", i),
            dbg_rdata, mregs[i]);
    end
  endtask

  task automatic read_reg(input int i,
                          output logic [7:0] v);
    dbg_raddr = 3'(i);
    #1;
    v = dbg_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int c;
    for (int i = 0; i < 256; i++) begin
      mmem[i] = 0;
      tbmem[i] = 0;
    end
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    rom_clear();

    // asynchronous reset, before any clock edge
    #1 reset = 1'b0;
    #2;
    check("rst_imem_addr", imem_addr, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_addr", dmem_addr, 0);
    check("rst_dmem_wdata", dmem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_retired", retired, 0);
    check_regs();
    tick();
    reset = 1'b1;

    // two ADDIs then jump-to-self; start during FETCH
    rom_clear();
    rom[0] = enc(OP_ADDI, 1, 3);
    rom[1] = enc(OP_ADDI, 1, 3);
    model_run();
    start = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("t1_done_cycle6", done, 0);
    tick();
    check("t1_done_cycle7", done, 1);
    check("t1_busy", busy, 0);
    check("t1_retired", retired, 3);
    @(negedge clk);
    #1;
    check("t1_queue", exp_q.size(), 0);
    read_reg(1, v);
    check("t1_r1", v, 6);
    check_regs();

    // restart from HALT keeps registers
    launch();
    check("restart_done_fall", done, 0);
    check("restart_busy", busy, 1);
    check("restart_retired", retired, 0);
    check("restart_pc", imem_addr, 0);
    wait_done(200);
    read_reg(1, v);
    check("restart_r1", v, 12);
    check_regs();

    // XOR self-clear then ANDI
    do_reset();
    rom_clear();
    rom[0] = enc(OP_ADDI, 2, 3);
    rom[1] = enc(OP_ADDI, 2, 2);
    rom[2] = enc(OP_XOR, 2, 2);
    rom[3] = enc(OP_ANDI, 2, 7);
    launch();
    wait_done(200);
    read_reg(2, v);
    check("t2_r2", v, 0);
    check_regs();

    // load with three stall cycles
    do_reset();
    rom_clear();
    rom[0] = enc(OP_ADDI, 4, 1);
    rom[1] = enc(OP_LS, 4, 4);
    rom[2] = enc(OP_LD, 3, 4);
    tbmem[16] = 'hA5;
    mmem[16] = 'hA5;
    force_stall = 3;
    launch();
    wait_done(200);
    force_stall = -1;
    check("t3_req_cycles", last_req_len, 4);
    read_reg(3, v);
    check("t3_r3", v, 'hA5);
    check_regs();

    // BEQ taken backwards
    do_reset();
    rom_clear();
    rom[0] = {OP_J, 6'd5};
    rom[5] = {OP_BEQ, 1'b0, 1'b0, 4'b1110};
    launch();
    wait_done(200);
    check("t4_taken_pc", imem_addr, 3);

    // BEQ not taken
    do_reset();
    rom_clear();
    rom[0] = enc(OP_ADDI, 0, 1);
    rom[1] = {OP_J, 6'd5};
    rom[5] = {OP_BEQ, 1'b0, 1'b0, 4'b1110};
    launch();
    wait_done(200);
    check("t4_fall_pc", imem_addr, 6);

    // reset during the MEM wait of a store
    do_reset();
    rom_clear();
    rom[0] = enc(OP_ADDI, 5, 3);
    rom[1] = enc(OP_ST, 5, 6);
    tbmem[0] = 'h5A;
    force_stall = 20;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (!dmem_req && c < 20) begin
      tick();
      c++;
    end
    check("t5_in_mem", dmem_req, 1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("t5_req_drop", dmem_req, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_retired", retired, 0);
    check("t5_pc", imem_addr, 0);
    check("t5_no_write", tbmem[0], 'h5A);
    tick();
    tick();
    reset = 1'b1;
    force_stall = -1;
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    exp_q.delete();
    check_regs();

    // randomized programs, registers carried over
    for (int i = 0; i < 256; i++) begin
      mmem[i] = $urandom_range(0, 255);
      tbmem[i] = mmem[i];
    end
    noise = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int len;
      if (r % 10 == 0) do_reset();
      rom_clear();
      len = $urandom_range(8, 30);
      for (int p = 0; p < len; p++) begin
        int o;
        o = $urandom_range(0, 6);
        if (o == 1)
          rom[p] = {OP_BEQ,
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'b0,
                    3'($urandom_range(1, 7))};
        else
          rom[p] = enc(3'(o),
                       $urandom_range(0, 7),
                       $urandom_range(0, 7));
      end
      launch();
      wait_done(2000);
      check_regs();
    end
    noise = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
